// File: rtl/stage_pkg.sv
// stage_pkg: state encodings and stage geometry shared by the stage scroller.
package stage_pkg;

    localparam int STAGE_AW       = 9;
    localparam int STAGE_SW       = 2;
    localparam int ROWS_PER_STAGE = 1 << (STAGE_AW - STAGE_SW);
    localparam int LEN_LSB        = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HREQ,
        S_HLAT,
        S_RREQ,
        S_RLAT,
        S_HOLD,
        S_DONE
    } state_t;

endpackage

// File: rtl/stage_scroller.sv
// stage_scroller: ROM-facing row sequencer; reads a stage header, then serves one row per tick.
// STAGE_SCROLLER_LOOP_EN makes a finished stage wrap back to row 1 instead of ending.
module stage_scroller
    import stage_pkg::*;
#(
    parameter int AW = STAGE_AW,
    parameter int DW = 32,
    parameter int SW = STAGE_SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] stage_sel,
    input  logic          tick,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] row,
    output logic          row_new,
    output logic          busy,
    output logic          done
);

    localparam int LW = AW - SW;

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [LW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] len_q, len_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] row_q, row_d;
    logic          row_new_q, row_new_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Addresses are built as {stage, offset} so an offset can never carry into the next stage.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        pend_d    = pend_q;
        addr_d    = addr_q;
        row_d     = row_q;
        row_new_d = 1'b0;
        if (start) begin
            sel_d   = stage_sel;
            addr_d  = {stage_sel, {LW{1'b0}}};
            ptr_d   = '0;
            pend_d  = 1'b0;
            state_d = S_HREQ;
        end else begin
            case (state_q)
                S_HREQ: begin
                    pend_d  = pend_q | tick;
                    state_d = S_HLAT;
                end
                S_HLAT: begin
                    len_d = rom_data[LEN_LSB +: LW];
                    if (rom_data[LEN_LSB +: LW] == '0) begin
                        pend_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        pend_d  = pend_q | tick;
                        ptr_d   = LW'(1);
                        addr_d  = {sel_q, LW'(1)};
                        state_d = S_RREQ;
                    end
                end
                S_RREQ: begin
                    pend_d  = pend_q | tick;
                    state_d = S_RLAT;
                end
                S_RLAT: begin
                    pend_d    = pend_q | tick;
                    row_d     = rom_data;
                    row_new_d = 1'b1;
                    state_d   = S_HOLD;
                end
                S_HOLD: begin
                    if (tick || pend_q) begin
                        pend_d = 1'b0;
                        if (ptr_q == len_q) begin
`ifdef STAGE_SCROLLER_LOOP_EN
                            ptr_d   = LW'(1);
                            addr_d  = {sel_q, LW'(1)};
                            state_d = S_RREQ;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            ptr_d   = ptr_q + LW'(1);
                            addr_d  = {sel_q, ptr_q + LW'(1)};
                            state_d = S_RREQ;
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            ptr_q     <= '0;
            len_q     <= '0;
            pend_q    <= 1'b0;
            addr_q    <= '0;
            row_q     <= '0;
            row_new_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            pend_q    <= pend_d;
            addr_q    <= addr_d;
            row_q     <= row_d;
            row_new_q <= row_new_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rom_addr = addr_q;
    assign row      = row_q;
    assign row_new  = row_new_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_stage_scroller.sv
// tb_stage_scroller: directed per-cycle vectors against stage_scroller with a behavioural registered ROM.
module tb_stage_scroller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  stage_sel = 2'd0;
    logic        tick = 1'b0;
    logic [8:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] row;
    logic        row_new;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:511];
    int          total = 0;
    int          passed = 0;

    typedef struct {
        logic        s;
        logic [1:0]  sel;
        logic        t;
        logic [8:0]  a;
        logic [31:0] r;
        logic        rn;
        logic        b;
        logic        d;
    } vec_t;

    vec_t vq[$];

    stage_scroller dut (
        .clk(clk), .rst(rst), .start(start), .stage_sel(stage_sel), .tick(tick),
        .rom_addr(rom_addr), .rom_data(rom_data), .row(row), .row_new(row_new),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic chk(input string name, input logic [8:0] a, input logic [31:0] r,
                       input logic rn, input logic b, input logic d);
        total++;
        if (rom_addr !== a || row !== r || row_new !== rn || busy !== b || done !== d)
            $display("FAIL %s: got addr=%h row=%h row_new=%b busy=%b done=%b, want addr=%h row=%h row_new=%b busy=%b done=%b",
                     name, rom_addr, row, row_new, busy, done, a, r, rn, b, d);
        else
            passed++;
    endtask

    task automatic step(input logic s, input logic [1:0] sel, input logic t);
        start = s;
        stage_sel = sel;
        tick = t;
        @(posedge clk);
        #1;
        start = 1'b0;
        tick = 1'b0;
    endtask

    task automatic v(input logic s, input logic [1:0] sel, input logic t, input logic [8:0] a,
                     input logic [31:0] r, input logic rn, input logic b, input logic d);
        vq.push_back('{s: s, sel: sel, t: t, a: a, r: r, rn: rn, b: b, d: d});
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hDEAD_0000 | i;
        mem[9'h000] = 32'hFFFF_FF08;
        for (int i = 1; i <= 8; i++) mem[i] = 32'hC0 + i;
        mem[9'h080] = 32'h0000_0183;
        mem[9'h081] = 32'hA1;
        mem[9'h082] = 32'hA2;
        mem[9'h083] = 32'hA3;
        mem[9'h100] = 32'h0000_0080;
        mem[9'h180] = 32'h0000_0002;
        mem[9'h181] = 32'hB1;
        mem[9'h182] = 32'hB2;

        // stage 1, three rows, then end
        v(1,1,0, 9'h080, 32'h0,  0,1,0);
        v(0,0,0, 9'h080, 32'h0,  0,1,0);
        v(0,0,0, 9'h081, 32'h0,  0,1,0);
        v(0,0,0, 9'h081, 32'h0,  0,1,0);
        v(0,0,0, 9'h081, 32'hA1, 1,1,0);
        v(0,0,0, 9'h081, 32'hA1, 0,1,0);
        v(0,0,1, 9'h082, 32'hA1, 0,1,0);
        v(0,0,0, 9'h082, 32'hA1, 0,1,0);
        v(0,0,0, 9'h082, 32'hA2, 1,1,0);
        v(0,0,1, 9'h083, 32'hA2, 0,1,0);
        v(0,0,0, 9'h083, 32'hA2, 0,1,0);
        v(0,0,0, 9'h083, 32'hA3, 1,1,0);
        v(0,0,1, 9'h083, 32'hA3, 0,0,1);
        v(0,0,1, 9'h083, 32'hA3, 0,0,1);
        // stage 2, empty
        v(1,2,0, 9'h100, 32'hA3, 0,1,0);
        v(0,0,0, 9'h100, 32'hA3, 0,1,0);
        v(0,0,0, 9'h100, 32'hA3, 0,0,1);
        v(0,0,0, 9'h100, 32'hA3, 0,0,1);
        // stage 0, pending tick merging
        v(1,0,0, 9'h000, 32'hA3, 0,1,0);
        v(0,0,0, 9'h000, 32'hA3, 0,1,0);
        v(0,0,0, 9'h001, 32'hA3, 0,1,0);
        v(0,0,0, 9'h001, 32'hA3, 0,1,0);
        v(0,0,0, 9'h001, 32'hC1, 1,1,0);
        v(0,0,1, 9'h002, 32'hC1, 0,1,0);
        v(0,0,1, 9'h002, 32'hC1, 0,1,0);
        v(0,0,1, 9'h002, 32'hC2, 1,1,0);
        v(0,0,0, 9'h003, 32'hC2, 0,1,0);
        v(0,0,0, 9'h003, 32'hC2, 0,1,0);
        v(0,0,0, 9'h003, 32'hC3, 1,1,0);
        v(0,0,0, 9'h003, 32'hC3, 0,1,0);
        v(0,0,0, 9'h003, 32'hC3, 0,1,0);
        // fetch row 5, abort with start of stage 2
        v(0,0,1, 9'h004, 32'hC3, 0,1,0);
        v(0,0,0, 9'h004, 32'hC3, 0,1,0);
        v(0,0,0, 9'h004, 32'hC4, 1,1,0);
        v(0,0,1, 9'h005, 32'hC4, 0,1,0);
        v(1,2,0, 9'h100, 32'hC4, 0,1,0);
        v(0,0,0, 9'h100, 32'hC4, 0,1,0);
        v(0,0,0, 9'h100, 32'hC4, 0,0,1);
        v(0,0,0, 9'h100, 32'hC4, 0,0,1);
        // start and tick together: tick discarded
        v(1,1,1, 9'h080, 32'hC4, 0,1,0);
        v(0,0,0, 9'h080, 32'hC4, 0,1,0);
        v(0,0,0, 9'h081, 32'hC4, 0,1,0);
        v(0,0,0, 9'h081, 32'hC4, 0,1,0);
        v(0,0,0, 9'h081, 32'hA1, 1,1,0);
        v(0,0,0, 9'h081, 32'hA1, 0,1,0);
        v(0,0,0, 9'h081, 32'hA1, 0,1,0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_held", 9'h000, 32'h0, 0,0,0);
        rst = 1'b0;
        step(0,0,1);
        chk("idle_tick_ignored", 9'h000, 32'h0, 0,0,0);

        // reset asserted asynchronously while in HLAT
        step(1,3,0);
        step(0,0,0);
        chk("in_hlat", 9'h180, 32'h0, 0,1,0);
        #2 rst = 1'b1;
        #1 chk("async_reset", 9'h000, 32'h0, 0,0,0);
        @(negedge clk);
        rst = 1'b0;
        step(0,0,0);
        chk("idle_after_reset", 9'h000, 32'h0, 0,0,0);
        repeat (3) step(0,0,0);
        chk("still_idle", 9'h000, 32'h0, 0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].s, vq[i].sel, vq[i].t);
            chk($sformatf("vec%0d", i), vq[i].a, vq[i].r, vq[i].rn, vq[i].b, vq[i].d);
        end

        // stage 3, len 2: end or wrap at the last row
        step(1,3,0);
        chk("s3_start", 9'h180, 32'hA1, 0,1,0);
        repeat (3) step(0,0,0);
        step(0,0,0);
        chk("s3_row1", 9'h181, 32'hB1, 1,1,0);
        step(0,0,1);
        step(0,0,0);
        step(0,0,0);
        chk("s3_row2", 9'h182, 32'hB2, 1,1,0);
        step(0,0,1);
`ifdef STAGE_SCROLLER_LOOP_EN
        chk("s3_wrap", 9'h181, 32'hB2, 0,1,0);
        step(0,0,0);
        step(0,0,0);
        chk("s3_row1_again", 9'h181, 32'hB1, 1,1,0);
        step(0,0,1);
        step(0,0,0);
        step(0,0,0);
        chk("s3_row2_again", 9'h182, 32'hB2, 1,1,0);
        step(0,0,1);
        chk("s3_wrap_again", 9'h181, 32'hB2, 0,1,0);
`else
        chk("s3_done", 9'h182, 32'hB2, 0,0,1);
        step(0,0,1);
        chk("s3_done_hold", 9'h182, 32'hB2, 0,0,1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
